// File: rtl/pet_uart_keyq.sv
// Queues UART bytes and replays each one as a timed PET key-matrix press, optionally with SHIFT held.
// Key shows 3 edges after the strobe edge; bytes arriving while the queue is full are dropped (sticky overflow).
module pet_uart_keyq #(
    parameter int FIFO_DEPTH     = 16,
    parameter int PRESS_CYCLES   = 2000000,
    parameter int RELEASE_CYCLES = 1000000,
    parameter int SHIFT_ROW      = 8,
    parameter int SHIFT_COL      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_data,
    input  logic       uart_strobe,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_PRESS, ST_RELEASE} state_t;

    function automatic logic [7:0] ent(input int row, input int col);
        return {1'b1, 4'(row), 3'(col)};
    endfunction

    // PET-2001 graphics keyboard matrix; result is {valid, row[3:0], col[2:0]}.
    function automatic logic [7:0] lookup(input logic [6:0] code);
        logic [6:0] c;
        logic [7:0] r;
        c = (code >= 7'h61 && code <= 7'h7A) ? code - 7'h20 : code;
        r = 8'h00;
        case (c)
            7'h21: r = ent(0, 0);  7'h23: r = ent(0, 1);  7'h25: r = ent(0, 2);
            7'h26: r = ent(0, 3);  7'h28: r = ent(0, 4);  7'h5F: r = ent(0, 5);
            7'h22: r = ent(1, 0);  7'h24: r = ent(1, 1);  7'h27: r = ent(1, 2);
            7'h5C: r = ent(1, 3);  7'h29: r = ent(1, 4);  7'h08: r = ent(1, 7);
            7'h51: r = ent(2, 0);  7'h45: r = ent(2, 1);  7'h54: r = ent(2, 2);
            7'h55: r = ent(2, 3);  7'h4F: r = ent(2, 4);  7'h5E: r = ent(2, 5);
            7'h37: r = ent(2, 6);  7'h39: r = ent(2, 7);
            7'h57: r = ent(3, 0);  7'h52: r = ent(3, 1);  7'h59: r = ent(3, 2);
            7'h49: r = ent(3, 3);  7'h50: r = ent(3, 4);  7'h38: r = ent(3, 6);
            7'h2F: r = ent(3, 7);
            7'h41: r = ent(4, 0);  7'h44: r = ent(4, 1);  7'h47: r = ent(4, 2);
            7'h4A: r = ent(4, 3);  7'h4C: r = ent(4, 4);  7'h34: r = ent(4, 6);
            7'h36: r = ent(4, 7);
            7'h53: r = ent(5, 0);  7'h46: r = ent(5, 1);  7'h48: r = ent(5, 2);
            7'h4B: r = ent(5, 3);  7'h3A: r = ent(5, 4);  7'h35: r = ent(5, 6);
            7'h2A: r = ent(5, 7);
            7'h5A: r = ent(6, 0);  7'h43: r = ent(6, 1);  7'h42: r = ent(6, 2);
            7'h4D: r = ent(6, 3);  7'h3B: r = ent(6, 4);  7'h0D: r = ent(6, 5);
            7'h31: r = ent(6, 6);  7'h33: r = ent(6, 7);
            7'h58: r = ent(7, 0);  7'h56: r = ent(7, 1);  7'h4E: r = ent(7, 2);
            7'h2C: r = ent(7, 3);  7'h3F: r = ent(7, 4);  7'h32: r = ent(7, 6);
            7'h2B: r = ent(7, 7);
            7'h40: r = ent(8, 1);  7'h5D: r = ent(8, 2);  7'h3E: r = ent(8, 4);
            7'h30: r = ent(8, 6);  7'h2D: r = ent(8, 7);
            7'h5B: r = ent(9, 1);  7'h20: r = ent(9, 2);  7'h3C: r = ent(9, 3);
            7'h2E: r = ent(9, 6);  7'h3D: r = ent(9, 7);
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic          in_vld_q, in_vld_d;
    logic [7:0]    in_dat_q, in_dat_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic [3:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic          shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en, rd_en, empty;
    logic [7:0]    lk;
    logic [7:0]    key_bits;

    // Full is taken from the registered flag, so a pop in the same cycle never frees room for a write.
    always_comb begin
        in_vld_d = uart_strobe;
        in_dat_d = uart_data;
        empty    = (wptr_q == rptr_q);
        wr_en    = in_vld_q && !full_q;
        rd_en    = (state_q == ST_IDLE) && !empty;
        wptr_d   = wptr_q + PW'(wr_en);
        rptr_d   = rptr_q + PW'(rd_en);
        full_d   = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
        ovf_d    = ovf_q || (in_vld_q && full_q);
    end

    always_comb begin
        lk      = lookup(code_q[6:0]);
        state_d = state_q;
        code_d  = code_q;
        row_d   = row_q;
        col_d   = col_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    code_d  = mem_q[rptr_q[AW-1:0]];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                row_d   = lk[6:3];
                col_d   = lk[2:0];
                shift_d = code_q[7];
                if (lk[7]) begin
                    state_d = ST_PRESS;
                    cnt_d   = CW'(PRESS_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CW'(RELEASE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_vld_q <= 1'b0;
            in_dat_q <= 8'h00;
            wptr_q   <= '0;
            rptr_q   <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= ST_IDLE;
            code_q   <= 8'h00;
            row_q    <= 4'h0;
            col_q    <= 3'h0;
            shift_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            in_vld_q <= in_vld_d;
            in_dat_q <= in_dat_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            code_q   <= code_d;
            row_q    <= row_d;
            col_q    <= col_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= in_dat_q;
        end
    end

    always_comb begin
        key_bits = 8'h00;
        if (state_q == ST_PRESS) begin
            if (keyrow == row_q) begin
                key_bits[col_q] = 1'b1;
            end
            if (shift_q && keyrow == 4'(SHIFT_ROW)) begin
                key_bits[3'(SHIFT_COL)] = 1'b1;
            end
        end
        keyin = ~key_bits;
    end

    assign fifo_full = full_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != ST_IDLE) || !empty;

endmodule

// File: doc/pet_uart_keyq.md
Name: pet_uart_keyq

Overview:
Queued, parametrised UART-to-PET keyboard injector. Buffers received bytes in a FIFO and replays each one as a timed key press on the PET key matrix, with optional SHIFT held alongside the key. Separate press and release intervals guarantee the PET scan routine sees each press and each release, so pasted text at full UART rate is not lost. Sits between the UART receiver and the PIA keyboard column input, in parallel with the physical keyboard path.

Parameters:
FIFO_DEPTH, 16, byte entries in the queue; power of 2, minimum 2.
PRESS_CYCLES, 2000000, clocks the key is held down (40 ms at 50 MHz); minimum 1.
RELEASE_CYCLES, 1000000, clocks with no key down before the next byte is popped (20 ms); minimum 1.
SHIFT_ROW, 8, matrix row of the left SHIFT key.
SHIFT_COL, 0, matrix column of the left SHIFT key.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
uart_data  in  8  received byte; bit7=1 requests SHIFT with key for code bit[6:0]
uart_strobe  in  1  one-cycle pulse; uart_data valid in the same cycle
keyrow  in  4  row currently selected by the PIA scan
keyin  out  8  column return, active-low; 8'hFF when nothing is pressed
fifo_full  out  1  queue full
overflow  out  1  sticky; a byte was dropped because the queue was full
busy  out  1  high when the FSM is not IDLE or the queue is not empty

Behaviour:
- Reset: FIFO empty, pointers 0, overflow=0, FSM=IDLE, no key latched, keyin=8'hFF, busy=0, fifo_full=0. Reset mid-press releases the key on the next cycle and discards the queue.
- FIFO write: on uart_strobe, if not full, write uart_data and advance wptr. If full, drop the byte and set overflow=1; it stays 1 until reset.
- Full is evaluated before any pop in the same cycle. A strobe while full is dropped even if a pop occurs in that cycle.
- Pointers are $clog2(FIFO_DEPTH)+1 bits with wrap bit. empty = pointers equal; full = low bits equal and wrap bits differ.
- FSM states IDLE, LOOKUP, PRESS, RELEASE:
  - IDLE: if !empty, pop the head byte into code_r and go to LOOKUP.
  - LOOKUP: register lookup(code_r[6:0]) into {valid,row,col} and shift_r=code_r[7]. If valid, go to PRESS and load cnt=PRESS_CYCLES-1. If not valid, drop the byte and go to IDLE.
  - PRESS: key asserted. Decrement cnt. At cnt==0, go to RELEASE and load cnt=RELEASE_CYCLES-1.
  - RELEASE: no key asserted. At cnt==0, go to IDLE.
- Lookup is the standard PET-2001 ASCII-to-matrix table (row 0-9, col 0-7), combinational, 7-bit index. Lowercase maps as uppercase. Codes with no entry are invalid.
- Latency: with the strobe sampled at edge t and an empty queue, the key is visible on keyin after edge t+3 (write, pop, lookup). It is held exactly PRESS_CYCLES cycles. The next byte's key appears RELEASE_CYCLES+2 cycles after release.
- keyin (combinational from keyrow and registered state) = ~(A | B):
  - A = (1<<col) when in PRESS and keyrow==row.
  - B = (1<<SHIFT_COL) when in PRESS, shift_r=1 and keyrow==SHIFT_ROW.
  - If row==SHIFT_ROW, both bits are cleared. keyrow values 10-15 give 8'hFF.
- Counter width is $clog2(max(PRESS_CYCLES,RELEASE_CYCLES)); arithmetic is unsigned with no wrap past 0.
- fifo_full is registered and matches the pointer state.

Test Plan:
- PRESS_CYCLES=8, RELEASE_CYCLES=4. Strobe 0x41 'A' -> keyin=8'hFE only when keyrow=4, for exactly 8 cycles starting 3 cycles after the strobe edge; 8'hFF on all other rows and cycles.
- Strobe 0xC1 (shifted 'A') -> during PRESS, keyrow=4 gives 8'hFE and keyrow=8 gives 8'hFE (SHIFT col 0). After release, all rows give 8'hFF.
- Back-to-back strobes "HI" (0x48,0x49) on consecutive cycles -> H (row5, keyin=8'hFB) for 8 cycles, 4 idle cycles plus 2 pop/lookup cycles, then I (row3, keyin=8'hF7) for 8 cycles; busy drops after the final release.
- FIFO_DEPTH=4, 6 strobes while the FSM holds the first press -> fifo_full=1 after the 5th accepted byte, the 6th byte is dropped, overflow=1, and exactly 5 presses occur in order.
- Strobe 0x01 (unmapped) followed by 0x20 -> no press for 0x01; space (row9, keyin=8'hFB) is pressed after 0x01 is dropped.
- Reset asserted mid-PRESS with 3 bytes queued -> next cycle keyin=8'hFF, busy=0, overflow=0, and no further presses.
